// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding,
// timeout-action encodings and the ch_idx width helper.
package reset_seq_pkg;

  // Sequencer state: HOLD counts clean cycles, RELEASE staggers the channel
  // releases, RUN counts the cycle budget once everything is out of reset.
  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

  // Action taken when the run-cycle budget expires.
  localparam int TO_PULSE   = 0;  // pulse timeout, stay in RUN
  localparam int TO_RESTART = 1;  // pulse timeout and replay the release sequence

  // ch_idx must be able to hold NUM_CH itself (one past the last channel).
  function automatic int ch_idx_width(input int num_ch);
    return (num_ch < 1) ? 1 : $clog2(num_ch + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Signal bundle between the reset sequencer and the blocks it controls.
// The master side is the sequencer; the slave side is its environment.
interface reset_sequencer_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);

  logic              sw_rst_req;    // level soft-reset request
  logic [NUM_CH-1:0] rst_out_n;     // per-channel active-low resets
  logic              all_released;  // every channel out of reset
  logic [CNT_W-1:0]  run_cycles;    // saturating cycles spent in RUN
  logic              timeout;       // one-cycle budget-expired pulse

  modport master (
    input  sw_rst_req,
    output rst_out_n,
    output all_released,
    output run_cycles,
    output timeout
  );

  modport slave (
    output sw_rst_req,
    input  rst_out_n,
    input  all_released,
    input  run_cycles,
    input  timeout
  );

endinterface

// File: rtl/reset_sequencer.sv
// Reset generator / sequencer. Assertion of every channel is immediate on
// rst; release is synchronous and staggered, channel 0 first, so no block
// leaves reset on the same edge as its neighbour. A soft-reset request and an
// optional run-cycle budget reuse the same sequence. All outputs come
// straight from flops.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int HOLD_CYCLES  = 2,
  parameter int STAGE_GAP    = 4,
  parameter int RUN_LIMIT    = 0,
  parameter int TIMEOUT_MODE = TO_PULSE,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  reset_sequencer_if.master  bus
);

  localparam int               IDX_W     = ch_idx_width(NUM_CH);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [IDX_W-1:0] LAST_CH   = IDX_W'(NUM_CH - 1);
  localparam bit               RUN_EN    = (RUN_LIMIT != 0);
  localparam bit               RESTART   = (TIMEOUT_MODE == TO_RESTART);

  state_e             state_q,    state_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]   gap_cnt_q,  gap_cnt_d;
  logic [CNT_W-1:0]   run_cnt_q,  run_cnt_d;
  logic [IDX_W-1:0]   ch_idx_q,   ch_idx_d;
  logic [NUM_CH-1:0]  rst_n_q,    rst_n_d;
  logic               all_rel_q,  all_rel_d;
  logic               timeout_q,  timeout_d;
  // Set once the budget pulse has fired so a saturated counter parked on
  // RUN_LIMIT-1 cannot produce a second pulse before the next release.
  logic               to_fired_q, to_fired_d;

  // Next-state and next-output logic; priority is sw request > timeout > progression.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    run_cnt_d  = run_cnt_q;
    ch_idx_d   = ch_idx_q;
    rst_n_d    = rst_n_q;
    all_rel_d  = all_rel_q;
    timeout_d  = 1'b0;
    to_fired_d = to_fired_q;

    if (bus.sw_rst_req) begin
      // Soft reset: re-assert everything and hold the clean-cycle count at 0.
      state_d    = HOLD;
      hold_cnt_d = '0;
      gap_cnt_d  = '0;
      run_cnt_d  = '0;
      ch_idx_d   = '0;
      rst_n_d    = '0;
      all_rel_d  = 1'b0;
      to_fired_d = 1'b0;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d = '0;
            rst_n_d    = NUM_CH'(1);
            gap_cnt_d  = '0;
            run_cnt_d  = '0;
            ch_idx_d   = IDX_W'(1);
            if (NUM_CH == 1) begin
              state_d   = RUN;
              all_rel_d = 1'b1;
            end else begin
              state_d   = RELEASE;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end

        RELEASE: begin
          if (gap_cnt_q == GAP_LAST) begin
            // Release exactly the next channel in index order.
            rst_n_d   = rst_n_q | (NUM_CH'(1) << ch_idx_q);
            gap_cnt_d = '0;
            ch_idx_d  = ch_idx_q + 1'b1;
            if (ch_idx_q == LAST_CH) begin
              state_d   = RUN;
              all_rel_d = 1'b1;
              run_cnt_d = '0;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end

        RUN: begin
          if (run_cnt_q != CNT_MAX) begin
            run_cnt_d = run_cnt_q + 1'b1;
          end
          if (RUN_EN && !to_fired_q && (run_cnt_q == RUN_LAST)) begin
            timeout_d  = 1'b1;
            to_fired_d = 1'b1;
            if (RESTART) begin
              // Budget expired: drop every channel and replay the sequence.
              state_d    = HOLD;
              hold_cnt_d = '0;
              gap_cnt_d  = '0;
              run_cnt_d  = '0;
              ch_idx_d   = '0;
              rst_n_d    = '0;
              all_rel_d  = 1'b0;
              to_fired_d = 1'b0;
            end
          end
        end

        default: begin
          // Unreachable encoding: fall back to a full reset.
          state_d    = HOLD;
          hold_cnt_d = '0;
          gap_cnt_d  = '0;
          run_cnt_d  = '0;
          ch_idx_d   = '0;
          rst_n_d    = '0;
          all_rel_d  = 1'b0;
          to_fired_d = 1'b0;
        end
      endcase
    end
  end

  // State register; rst clears every flop immediately, without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HOLD;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      run_cnt_q  <= '0;
      ch_idx_q   <= '0;
      rst_n_q    <= '0;
      all_rel_q  <= 1'b0;
      timeout_q  <= 1'b0;
      to_fired_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values together.
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      run_cnt_q  <= run_cnt_d;
      ch_idx_q   <= ch_idx_d;
      rst_n_q    <= rst_n_d;
      all_rel_q  <= all_rel_d;
      timeout_q  <= timeout_d;
      to_fired_q <= to_fired_d;
    end
  end

  assign bus.rst_out_n    = rst_n_q;
  assign bus.all_released = all_rel_q;
  assign bus.run_cycles   = run_cnt_q;
  assign bus.timeout      = timeout_q;

  // Released channels always form a contiguous run starting at channel 0.
  a_in_order: assert property (@(posedge clk) disable iff (rst)
    ((rst_n_q & NUM_CH'(rst_n_q + 1'b1)) == '0));

  // all_released is only ever high with every channel out of reset.
  a_all_rel: assert property (@(posedge clk) disable iff (rst)
    (all_rel_q |-> (&rst_n_q)));

endmodule
